// File: rtl/reaction_timer_core.sv
// Reaction-time trial engine: random fore-period countdown, GO indicator, reaction
// up-count with early-press and timeout detection. All outputs are registered.
module reaction_timer_core #(
  parameter int unsigned MIN_DELAY  = 32'd50_000_000,
  parameter int unsigned RANGE_BITS = 32'd27,
  parameter int unsigned TIMEOUT    = 32'd100_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rnd_in,
  input  logic        start,
  input  logic        btn,
  output logic        busy,
  output logic        go_led,
  output logic        done,
  output logic        early,
  output logic        timeout_flag,
  output logic [31:0] react_ticks
);

  localparam logic [31:0] MIN_DELAY_W = 32'(MIN_DELAY);
  localparam logic [31:0] TIMEOUT_W   = 32'(TIMEOUT);
  localparam logic [31:0] RANGE_MASK  = 32'((64'd1 << RANGE_BITS) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GO   = 2'd2
  } state_e;

  state_e      state_r, state_next_s;
  logic [31:0] cnt_r, cnt_next_s;
  logic [31:0] delay_s, cnt_inc_s;
  logic        busy_r, go_led_r, done_r, early_r, timeout_r;
  logic [31:0] react_r;
  logic        done_next_s, early_next_s, timeout_next_s;
  logic [31:0] react_next_s;

  assign delay_s   = MIN_DELAY_W + (rnd_in & RANGE_MASK);
  assign cnt_inc_s = cnt_r + 32'd1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; an early press in WAIT takes priority over delay expiry
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_WAIT;
        else       state_next_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (btn)                  state_next_s = ST_IDLE;
        else if (cnt_r == 32'd1)  state_next_s = ST_GO;
        else                      state_next_s = ST_WAIT;
      end
      ST_GO: begin
        if (btn || (cnt_inc_s == TIMEOUT_W)) state_next_s = ST_IDLE;
        else                                 state_next_s = ST_GO;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Counter and result next values; cnt_r counts the delay down in WAIT and ticks up in GO
  always_comb begin
    cnt_next_s     = cnt_r;
    done_next_s    = 1'b0;
    early_next_s   = early_r;
    timeout_next_s = timeout_r;
    react_next_s   = react_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          cnt_next_s     = delay_s;
          early_next_s   = 1'b0;
          timeout_next_s = 1'b0;
          react_next_s   = 32'd0;
        end else begin
          cnt_next_s = cnt_r;
        end
      end
      ST_WAIT: begin
        if (btn) begin
          early_next_s = 1'b1;
          done_next_s  = 1'b1;
        end else if (cnt_r == 32'd1) begin
          cnt_next_s = 32'd0;
        end else begin
          cnt_next_s = cnt_r - 32'd1;
        end
      end
      ST_GO: begin
        if (btn) begin
          react_next_s = cnt_inc_s;
          done_next_s  = 1'b1;
        end else if (cnt_inc_s == TIMEOUT_W) begin
          react_next_s   = TIMEOUT_W;
          timeout_next_s = 1'b1;
          done_next_s    = 1'b1;
        end else begin
          cnt_next_s = cnt_inc_s;
        end
      end
      default: cnt_next_s = 32'd0;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= 32'd0;
      busy_r    <= 1'b0;
      go_led_r  <= 1'b0;
      done_r    <= 1'b0;
      early_r   <= 1'b0;
      timeout_r <= 1'b0;
      react_r   <= 32'd0;
    end else begin
      cnt_r     <= cnt_next_s;
      busy_r    <= (state_next_s != ST_IDLE);
      go_led_r  <= (state_next_s == ST_GO);
      done_r    <= done_next_s;
      early_r   <= early_next_s;
      timeout_r <= timeout_next_s;
      react_r   <= react_next_s;
    end
  end

  assign busy         = busy_r;
  assign go_led       = go_led_r;
  assign done         = done_r;
  assign early        = early_r;
  assign timeout_flag = timeout_r;
  assign react_ticks  = react_r;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Self-checking bench for reaction_timer_core: directed scenarios plus randomized trials
// predicted from press time, fore-period and timeout arithmetic.
module tb_reaction_timer_core;

  localparam int unsigned MIN_D = 10;
  localparam int unsigned RB    = 4;
  localparam int unsigned TMO   = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rnd_in = 32'd0;
  logic        start = 1'b0;
  logic        btn = 1'b0;
  logic        busy, go_led, done, early, timeout_flag;
  logic [31:0] react_ticks;

  int checks = 0;
  int errors = 0;

  reaction_timer_core #(.MIN_DELAY(MIN_D), .RANGE_BITS(RB), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .rnd_in(rnd_in), .start(start), .btn(btn),
    .busy(busy), .go_led(go_led), .done(done), .early(early),
    .timeout_flag(timeout_flag), .react_ticks(react_ticks)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_go"}, go_led, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_early"}, early, 0);
    check({tag, "_tmo"}, timeout_flag, 0);
    check({tag, "_react"}, react_ticks, 0);
  endtask

  // One trial: start at edge S, button goes high at relative edge p (p<=0: already high
  // when start is accepted). Outcome predicted from fore-period/timeout arithmetic.
  task automatic run_trial(input logic [31:0] rnd, input int p, input int gap, input bit noise);
    int d, pe, endk, kind, exp_react;
    d  = MIN_D + int'(rnd % (32'd1 << RB));
    pe = (p < 1) ? 1 : p;
    if (pe <= d) begin
      kind = 0; endk = pe; exp_react = 0;
    end else if (pe - d <= TMO) begin
      kind = 1; endk = pe; exp_react = pe - d;
    end else begin
      kind = 2; endk = d + TMO; exp_react = TMO;
    end
    @(negedge clk);
    start = 1'b1; rnd_in = rnd; btn = (p <= 0);
    @(posedge clk); #1;
    check("accept_busy", busy, 1);
    check("accept_go", go_led, 0);
    check("accept_done", done, 0);
    check("accept_react", react_ticks, 0);
    for (int k = 1; k <= endk; k++) begin
      @(negedge clk);
      start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      rnd_in = $urandom;
      btn = (k >= p);
      @(posedge clk); #1;
      check("go_led", go_led, (k >= d) && (k < endk));
      check("busy", busy, k < endk);
      check("done", done, k == endk);
    end
    check("res_early", early, kind == 0);
    check("res_tmo", timeout_flag, kind == 2);
    check("res_react", react_ticks, 32'(exp_react));
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      start = 1'b0; btn = 1'b0;
      @(posedge clk); #1;
      check("hold_done", done, 0);
      check("hold_busy", busy, 0);
      check("hold_early", early, kind == 0);
      check("hold_react", react_ticks, 32'(exp_react));
    end
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle");

    // Directed scenarios
    run_trial(32'h0000_0003, 18, 1, 1'b0);   // go at 13, react 5
    run_trial(32'h0000_0003, 5, 1, 1'b0);    // early during wait
    run_trial(32'hFFFF_FFFF, 1000, 1, 1'b0); // timeout, D=25
    run_trial(32'h0000_0000, 10, 1, 1'b0);   // press on expiry edge: early
    run_trial(32'h1234_5672, 13, 1, 1'b1);   // D=12, ignored starts while busy
    run_trial(32'h0000_0005, 35, 0, 1'b1);   // press on timeout edge: react 20, no flag
    run_trial(32'h0000_0005, 16, 1, 1'b0);   // react 1, started right after done
    run_trial(32'h0000_0007, 0, 1, 1'b0);    // button held at start: early at S+1

    // Asynchronous reset in the middle of GO
    @(negedge clk); start = 1'b1; rnd_in = 32'h0000_0003; btn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(posedge clk);
    #1; check("pre_reset_go", go_led, 1);
    #2; reset_n = 1'b0;
    #1; check_all_zero("mid_reset");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");
    run_trial(32'h0000_0003, 18, 1, 1'b0);

    // Randomized trials
    for (int t = 0; t < 30; t++) begin
      run_trial($urandom, int'($urandom_range(0, 48)), int'($urandom_range(0, 2)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
